// File: rtl/puf_pkg.sv
// Shared FSM state type, LFSR constants and small helpers for the PUF challenger/verifier.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SAMPLE,
        NEXT,
        FINISH
    } state_t;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    // Fibonacci step, shift left, feedback is the parity of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    // A challenge pair that compares an oscillator with itself carries no information.
    function automatic logic pair_invalid(input logic [7:0] v);
        return v[3:0] == v[7:4];
    endfunction

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR that generates PUF challenge pairs; load has priority over step.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);

    // Reset to a nonzero value so the register can never sit in the lock-up state.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= DEFAULT_SEED;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/puf_auth_ctrl.sv
// Challenger/verifier for the 4-bit RO PUF: enrolls a CRP table, then authenticates
// by replaying the same challenges and thresholding the accumulated Hamming distance.
module puf_auth_ctrl
    import puf_pkg::*;
#(
    parameter int  MEAS_CYCLES   = 16,
    parameter int  SETTLE_CYCLES = 4,
    parameter int  NUM_CRP       = 8,
    parameter int  MAX_HD        = 4,
    localparam int HDW           = $clog2(4 * NUM_CRP + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           mode,
    input  logic [7:0]     seed,
    output logic           puf_reset,
    output logic [3:0]     Cha0,
    output logic [3:0]     Cha1,
    output logic           Enable,
    input  logic [3:0]     Response,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic           error,
    output logic           enrolled,
    output logic [HDW-1:0] hd_total,
    output state_t         dbg_state
);

    localparam int CMAX = (MEAS_CYCLES > SETTLE_CYCLES) ? MEAS_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_CRP);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idx;
    logic           mode_q;
    logic [7:0]     enr_seed;
    logic [7:0]     seed_eff;
    logic [7:0]     load_val;
    logic [7:0]     lfsr_q;
    logic [7:0]     lfsr_nxt;
    logic           lfsr_load;
    logic           lfsr_step_en;
    logic           in_window;
    logic [3:0]     crp_table [NUM_CRP];

    puf_lfsr8 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step_en),
        .q        (lfsr_q)
    );

    assign seed_eff  = (seed == 8'h00) ? DEFAULT_SEED : seed;
    assign busy      = (state != IDLE) && (state != FINISH);
    assign done      = (state == FINISH);
    assign dbg_state = state;

    always_comb begin
        state_nxt    = state;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        load_val     = mode ? enr_seed : seed_eff;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode && !enrolled) begin
                        state_nxt = FINISH;
                    end else begin
                        lfsr_load = 1'b1;
                        state_nxt = pair_invalid(load_val) ? NEXT : CLEAR;
                    end
                end
            end
            CLEAR:   if (cnt == CW'(SETTLE_CYCLES - 1)) state_nxt = MEASURE;
            MEASURE: if (cnt == CW'(MEAS_CYCLES - 1)) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = NEXT;
            NEXT: begin
                // An invalid current pair means this NEXT is a skip, not a completed CRP.
                lfsr_step_en = 1'b1;
                if (!pair_invalid(lfsr_q) && idx == IW'(NUM_CRP - 1)) begin
                    state_nxt = FINISH;
                end else begin
                    state_nxt = pair_invalid(lfsr_step(lfsr_q)) ? NEXT : CLEAR;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Challenge outputs are registered from the value the LFSR holds next cycle.
    assign lfsr_nxt  = lfsr_load ? load_val : (lfsr_step_en ? lfsr_step(lfsr_q) : lfsr_q);
    assign in_window = (state_nxt == CLEAR) || (state_nxt == MEASURE) || (state_nxt == SAMPLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            mode_q    <= 1'b0;
            enr_seed  <= 8'h00;
            hd_total  <= '0;
            pass      <= 1'b0;
            error     <= 1'b0;
            enrolled  <= 1'b0;
            Cha0      <= 4'h0;
            Cha1      <= 4'h0;
            puf_reset <= 1'b0;
            Enable    <= 1'b0;
        end else begin
            state     <= state_nxt;
            Cha0      <= in_window ? lfsr_nxt[3:0] : 4'h0;
            Cha1      <= in_window ? lfsr_nxt[7:4] : 4'h0;
            puf_reset <= (state_nxt == CLEAR);
            Enable    <= (state_nxt == MEASURE);
            cnt       <= ((state == CLEAR || state == MEASURE) && state_nxt == state) ?
                         cnt + 1'b1 : '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        idx      <= '0;
                        hd_total <= '0;
                        pass     <= 1'b0;
                        error    <= 1'b0;
                        if (!mode) begin
                            enr_seed <= seed_eff;
                            enrolled <= 1'b0;
                        end else if (!enrolled) begin
                            error <= 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (mode_q) begin
                        hd_total <= hd_total + HDW'($countones(Response ^ crp_table[idx]));
                    end
                end
                NEXT: begin
                    if (!pair_invalid(lfsr_q)) idx <= idx + 1'b1;
                    if (state_nxt == FINISH) begin
                        if (mode_q) pass     <= (hd_total <= HDW'(MAX_HD));
                        else        enrolled <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The table is only trusted while enrolled is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state == SAMPLE && !mode_q) crp_table[idx] <= Response;
    end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Bench for puf_auth_ctrl: behavioural PUF model plus a spec-level reference for
// challenge order, skips, latency, Hamming distance and verdicts.
module tb_puf_auth_ctrl;
    import puf_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       puf_reset, Enable, busy, done, pass, error, enrolled;
    logic [3:0] Cha0, Cha1;
    logic [3:0] Response = 4'h0;
    logic [5:0] hd_total;
    state_t     dbg_state;

    puf_auth_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .puf_reset(puf_reset), .Cha0(Cha0), .Cha1(Cha1), .Enable(Enable),
        .Response(Response), .busy(busy), .done(done), .pass(pass), .error(error),
        .enrolled(enrolled), .hd_total(hd_total), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // PUF model: base response per challenge pair, xor a per-window flip mask.
    logic       model_kind = 1'b0;
    logic [3:0] const_resp = 4'hA;
    logic [3:0] rom [256];
    logic [3:0] flips [8];
    int         win = 0;
    logic       prev_drv_en = 1'b0;

    function automatic logic [3:0] model_base(input logic [7:0] pair);
        return model_kind ? rom[pair] : const_resp;
    endfunction

    always @(negedge clk) begin
        if (Enable) Response = model_base({Cha1, Cha0}) ^ flips[win[2:0]];
        if (prev_drv_en && !Enable) win++;
        prev_drv_en = Enable;
    end

    // Reference model state.
    logic [7:0] exp_q [$];
    int         exp_lat, exp_hd;
    logic       exp_pass, exp_err;
    logic       ref_enrolled = 1'b0;
    logic [7:0] ref_seed = 8'h00;
    logic [3:0] ref_tab [8];

    function automatic logic [7:0] nxt(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic predict(input logic m, input logic [7:0] s);
        logic [7:0] v;
        logic [3:0] r;
        int skips;
        exp_q.delete();
        exp_hd = 0; exp_pass = 1'b0; exp_err = 1'b0;
        if (m && !ref_enrolled) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
        v = m ? ref_seed : ((s == 8'h00) ? 8'hA5 : s);
        if (!m) ref_seed = v;
        skips = 0;
        while (exp_q.size() < 8) begin
            if (v[3:0] == v[7:4]) skips++;
            else exp_q.push_back(v);
            v = nxt(v);
        end
        exp_lat = 1 + 8 * (4 + 16 + 2) + skips;
        for (int i = 0; i < 8; i++) begin
            r = model_base(exp_q[i]) ^ flips[i];
            if (!m) ref_tab[i] = r;
            else exp_hd += $countones(r ^ ref_tab[i]);
        end
        if (m) exp_pass = (exp_hd <= 4);
        else ref_enrolled = 1'b1;
    endtask

    // Observations from the last session.
    logic [7:0] obs_q [$];
    int   lat, n_en, n_rst, n_rst_pre, first_en_cyc, bad_en, busy_gap;
    logic rst_cyc1, got_pass, got_err, got_enr;
    logic [5:0] got_hd;

    task automatic run_session(input logic m, input logic [7:0] s, input int extra_cyc);
        logic prev_en;
        obs_q.delete();
        n_en = 0; n_rst = 0; n_rst_pre = 0; first_en_cyc = 0; bad_en = 0; busy_gap = 0;
        rst_cyc1 = 1'b0; lat = -1; prev_en = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; seed = s; win = 0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = (cyc == extra_cyc);
            if (start) mode = !m;
            if (cyc == 1) rst_cyc1 = puf_reset;
            if (Enable && !prev_en) begin
                obs_q.push_back({Cha1, Cha0});
                if (first_en_cyc == 0) first_en_cyc = cyc;
            end
            if (Enable && Cha0 == Cha1) bad_en++;
            if (Enable) n_en++;
            if (puf_reset) n_rst++;
            if (puf_reset && first_en_cyc == 0) n_rst_pre++;
            prev_en = Enable;
            if (done) begin
                lat = cyc; got_pass = pass; got_err = error; got_hd = hd_total;
                got_enr = enrolled;
                break;
            end
            if (!busy) busy_gap++;
        end
        start = 1'b0;
    endtask

    function automatic int count_diffs();
        int d;
        d = (obs_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++; if ({puf_reset, Enable, Cha0, Cha1} !== 10'b0) begin bad++;
            $display("FAIL reset_puf_io got=%b exp=0", {puf_reset, Enable, Cha0, Cha1}); end
        total++; if ({busy, done, pass, error, enrolled, hd_total} !== 11'b0) begin bad++;
            $display("FAIL reset_status got=%b exp=0", {busy, done, pass, error, enrolled, hd_total}); end
        predict(1'b1, 8'h5A);
        run_session(1'b1, 8'h5A, 0);
        total++; if (lat !== 1) begin bad++; $display("FAIL noenroll_lat got=%0d exp=1", lat); end
        total++; if ({got_err, got_pass, got_hd} !== {1'b1, 1'b0, 6'd0}) begin bad++;
            $display("FAIL noenroll_verdict got err=%b pass=%b hd=%0d exp err=1 pass=0 hd=0",
                     got_err, got_pass, got_hd); end
    endtask

    task automatic test_enroll();
        model_kind = 1'b0;
        foreach (flips[i]) flips[i] = 4'h0;
        predict(1'b0, 8'h21);
        run_session(1'b0, 8'h21, 0);
        total++; if ((obs_q.size() > 0 ? obs_q[0] : 8'hxx) !== 8'h21) begin bad++;
            $display("FAIL enroll_first_pair got=%h exp=21", obs_q.size() > 0 ? obs_q[0] : 8'hxx); end
        total++; if ({rst_cyc1, n_rst_pre, first_en_cyc} !== {1'b1, 32'd4, 32'd5}) begin bad++;
            $display("FAIL enroll_window rst1=%b pre=%0d first_en=%0d exp 1/4/5",
                     rst_cyc1, n_rst_pre, first_en_cyc); end
        total++; if (n_en !== 128 || n_rst !== 32) begin bad++;
            $display("FAIL enroll_counts en=%0d rst=%0d exp 128/32", n_en, n_rst); end
        total++; if (lat !== 177) begin bad++; $display("FAIL enroll_lat got=%0d exp=177", lat); end
        total++; if (got_enr !== 1'b1) begin bad++; $display("FAIL enroll_flag got=%b exp=1", got_enr); end
        total++; if (count_diffs() != 0) begin bad++;
            $display("FAIL enroll_seq diffs=%0d exp=0", count_diffs()); end
        total++; if (busy_gap !== 0) begin bad++; $display("FAIL enroll_busy gaps=%0d exp=0", busy_gap); end
    endtask

    task automatic test_auth_same();
        predict(1'b1, 8'h77);
        run_session(1'b1, 8'h77, 0);
        total++; if (count_diffs() != 0 || obs_q.size() == 0 || obs_q[0] !== 8'h21) begin bad++;
            $display("FAIL auth_seq diffs=%0d exp=0", count_diffs()); end
        total++; if ({got_hd, got_pass, got_err} !== {6'd0, 1'b1, 1'b0}) begin bad++;
            $display("FAIL auth_verdict got hd=%0d pass=%b err=%b exp 0/1/0", got_hd, got_pass, got_err); end
        total++; if (lat !== 177) begin bad++; $display("FAIL auth_lat got=%0d exp=177", lat); end
    endtask

    task automatic test_threshold();
        int nbits;
        for (int n = 4; n <= 5; n++) begin
            foreach (flips[i]) flips[i] = 4'h0;
            nbits = 0;
            while (nbits < n) begin
                flips[$urandom_range(0, 7)][$urandom_range(0, 3)] = 1'b1;
                nbits = 0;
                foreach (flips[i]) nbits += $countones(flips[i]);
            end
            predict(1'b1, 8'($urandom_range(0, 255)));
            run_session(1'b1, 8'h00, 0);
            total++; if (got_hd !== 6'(n)) begin bad++;
                $display("FAIL thresh_hd got=%0d exp=%0d", got_hd, n); end
            total++; if (got_pass !== (n <= 4)) begin bad++;
                $display("FAIL thresh_pass got=%b exp=%b", got_pass, n <= 4); end
        end
        foreach (flips[i]) flips[i] = 4'h0;
    endtask

    task automatic test_seed_edge();
        predict(1'b0, 8'h33);
        run_session(1'b0, 8'h33, 0);
        total++; if ((obs_q.size() > 0 ? obs_q[0] : 8'hxx) !== 8'hCD) begin bad++;
            $display("FAIL seed33_first got=%h exp=cd", obs_q.size() > 0 ? obs_q[0] : 8'hxx); end
        total++; if (lat !== exp_lat || exp_lat < 179) begin bad++;
            $display("FAIL seed33_lat got=%0d exp=%0d", lat, exp_lat); end
        total++; if (bad_en !== 0) begin bad++; $display("FAIL seed33_invalid_enable got=%0d exp=0", bad_en); end
        total++; if (count_diffs() != 0) begin bad++; $display("FAIL seed33_seq diffs=%0d", count_diffs()); end
        predict(1'b0, 8'h00);
        run_session(1'b0, 8'h00, 0);
        total++; if ((obs_q.size() > 0 ? obs_q[0] : 8'hxx) !== 8'hA5) begin bad++;
            $display("FAIL seed00_first got=%h exp=a5", obs_q.size() > 0 ? obs_q[0] : 8'hxx); end
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL seed00_lat got=%0d exp=%0d", lat, exp_lat); end
    endtask

    task automatic test_random();
        model_kind = 1'b1;
        for (int it = 0; it < 3; it++) begin
            foreach (flips[i]) flips[i] = 4'h0;
            seed = 8'($urandom_range(1, 255));
            predict(1'b0, seed);
            run_session(1'b0, seed, 0);
            total++; if (lat !== exp_lat || count_diffs() != 0 || bad_en !== 0) begin bad++;
                $display("FAIL rand_enroll it=%0d lat=%0d exp=%0d diffs=%0d", it, lat, exp_lat, count_diffs()); end
            foreach (flips[i]) flips[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            predict(1'b1, 8'($urandom_range(0, 255)));
            run_session(1'b1, 8'($urandom_range(0, 255)), 0);
            total++; if (got_hd !== 6'(exp_hd) || got_pass !== exp_pass) begin bad++;
                $display("FAIL rand_auth it=%0d hd=%0d pass=%b exp hd=%0d pass=%b",
                         it, got_hd, got_pass, exp_hd, exp_pass); end
            total++; if (lat !== exp_lat || count_diffs() != 0) begin bad++;
                $display("FAIL rand_auth_seq it=%0d lat=%0d exp=%0d", it, lat, exp_lat); end
        end
        foreach (flips[i]) flips[i] = 4'h0;
        model_kind = 1'b0;
    endtask

    task automatic test_back_to_back();
        predict(1'b0, 8'h21);
        run_session(1'b0, 8'h21, 30);
        total++; if (lat !== exp_lat) begin bad++;
            $display("FAIL busy_start_lat got=%0d exp=%0d", lat, exp_lat); end
        total++; if (count_diffs() != 0 || got_enr !== 1'b1) begin bad++;
            $display("FAIL busy_start_seq diffs=%0d enrolled=%b", count_diffs(), got_enr); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; mode = 1'b1; seed = 8'h00;
        @(posedge clk);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++; if (Enable !== 1'b1) begin bad++; $display("FAIL midreset_pre_enable got=%b exp=1", Enable); end
        reset = 1'b1;
        @(negedge clk);
        total++; if ({Enable, puf_reset, busy, enrolled} !== 4'b0) begin bad++;
            $display("FAIL midreset_outputs got=%b exp=0000", {Enable, puf_reset, busy, enrolled}); end
        reset = 1'b0;
        ref_enrolled = 1'b0;
        predict(1'b1, 8'h00);
        run_session(1'b1, 8'h00, 0);
        total++; if (lat !== 1 || got_err !== 1'b1) begin bad++;
            $display("FAIL midreset_auth lat=%0d err=%b exp 1/1", lat, got_err); end
    endtask

    initial begin
        foreach (rom[i]) rom[i] = 4'($urandom_range(0, 15));
        foreach (flips[i]) flips[i] = 4'h0;
        test_reset();
        test_enroll();
        test_auth_same();
        test_threshold();
        test_seed_edge();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
